// File: rtl/ir_command_controller.sv
// ir_command_controller
// Bus-mapped front end for the IR transmitter. Holds the 4-bit direction
// command and issues single-cycle SEND_PACKET pulses. Requests come from a
// SEND_NOW register write or from a programmable periodic timer. After each
// pulse a hold-off window blocks further pulses and freezes COMMAND.
//
// Register map (offset from BASE_ADDR):
//   +0 CMD    RW [3:0] pending command, [7:4] read 0
//   +1 CTRL   RW [0] PERIODIC_EN, [1] SEND_NOW (write-1 one-shot, reads 0)
//   +2 STATUS RO SENT_COUNT, wraps 255 -> 0
//   +3 PERIOD RW periodic request every (PERIOD+1)*TICK_CYCLES cycles
//
// Bus handshake: BUS_WE / BUS_RE are single-cycle strobes qualified by an
// address hit. A write takes effect at the clock edge that samples BUS_WE.
// Read data appears on BUS_RDATA the cycle after BUS_RE. BUS_RDATA is 8'h00
// in every other cycle.
module ir_command_controller #(
  parameter logic [7:0] BASE_ADDR      = 8'h90,
  parameter int         TICK_CYCLES    = 100_000,
  parameter int         HOLDOFF_CYCLES = 2_000_000,
  parameter logic [7:0] PERIOD_RESET   = 8'd99
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [7:0] BUS_ADDR,
  input  logic [7:0] BUS_WDATA,
  input  logic       BUS_WE,
  input  logic       BUS_RE,
  output logic [7:0] BUS_RDATA,
  output logic [3:0] COMMAND,
  output logic       SEND_PACKET
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HOLD_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HOLDOFF = 1'b1;

  // Register state
  logic [3:0]         cmd_reg;
  logic               periodic_en;
  logic [7:0]         period_reg;
  logic [7:0]         sent_count;

  // Timer, request and sequencing state
  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         period_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               pending;
  logic [0:0]         state;

  // Decode
  logic [7:0]         offset;
  logic               hit;
  logic               wr_cmd;
  logic               wr_ctrl;
  logic               wr_period;
  logic               send_now;
  logic               period_wrap;
  logic               request;
  logic               fire;

  // Address decode, request merge and the fire condition
  always_comb begin
    offset      = BUS_ADDR - BASE_ADDR;
    hit         = (offset[7:2] == 6'd0);
    wr_cmd      = BUS_WE && hit && (offset[1:0] == 2'd0);
    wr_ctrl     = BUS_WE && hit && (offset[1:0] == 2'd1);
    wr_period   = BUS_WE && hit && (offset[1:0] == 2'd3);
    send_now    = wr_ctrl && BUS_WDATA[1];
    // A PERIOD write restarts the timer, so it also suppresses a wrap landing on the same edge.
    period_wrap = periodic_en && !wr_period && (presc_cnt == PRESC_LAST) &&
                  (period_cnt == period_reg);
    request     = send_now || period_wrap;
    fire        = (state == ST_IDLE) && (pending || request);
  end

  // Software-visible RW registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cmd_reg     <= 4'h0;
      periodic_en <= 1'b0;
      period_reg  <= PERIOD_RESET;
    end else begin
      if (wr_cmd)    cmd_reg     <= BUS_WDATA[3:0];
      if (wr_ctrl)   periodic_en <= BUS_WDATA[0];
      if (wr_period) period_reg  <= BUS_WDATA;
    end
  end

  // Periodic timer: prescaler ticks advance the period counter; both restart when disabled or reprogrammed
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      presc_cnt  <= '0;
      period_cnt <= 8'd0;
    end else if (!periodic_en || wr_period) begin
      presc_cnt  <= '0;
      period_cnt <= 8'd0;
    end else if (presc_cnt == PRESC_LAST) begin
      presc_cnt  <= '0;
      period_cnt <= (period_cnt == period_reg) ? 8'd0 : period_cnt + 8'd1;
    end else begin
      presc_cnt  <= presc_cnt + PRESC_W'(1);
    end
  end

  // Send sequencer: IDLE fires a pulse and latches COMMAND, HOLDOFF waits out the packet
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      pending     <= 1'b0;
      sent_count  <= 8'd0;
      SEND_PACKET <= 1'b0;
      COMMAND     <= 4'h0;
    end else begin
      SEND_PACKET <= fire;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            COMMAND    <= cmd_reg;
            pending    <= 1'b0;
            sent_count <= sent_count + 8'd1;
            hold_cnt   <= '0;
            state      <= ST_HOLDOFF;
          end
        end
        default: begin
          // Requests during hold-off collapse into a single pending flag.
          if (request) pending <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
      endcase
    end
  end

  // Registered read port, zero when not reading a mapped register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      BUS_RDATA <= 8'h00;
    end else if (BUS_RE && hit) begin
      case (offset[1:0])
        2'd0:    BUS_RDATA <= {4'h0, cmd_reg};
        2'd1:    BUS_RDATA <= {7'h00, periodic_en};
        2'd2:    BUS_RDATA <= sent_count;
        default: BUS_RDATA <= period_reg;
      endcase
    end else begin
      BUS_RDATA <= 8'h00;
    end
  end

endmodule

// File: tb/tb_ir_command_controller.sv
// Testbench for ir_command_controller with short tick/hold-off parameters.
// A reference model predicts every read response and every SEND_PACKET pulse,
// including the cycle it occurs and the command it carries, and pushes them
// into expected queues. A monitor on the falling edge pops and compares.
module tb_ir_command_controller;

  localparam logic [7:0] BASE  = 8'h90;
  localparam int         TICK  = 10;
  localparam int         HOLD  = 20;
  localparam int         W     = 40;

  logic       clk;
  logic       resetn;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic [3:0] command;
  logic       send_packet;

  int compared = 0;
  int failed   = 0;

  // Expected queues: [39:8] cycle index, [7:0] data
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pulse_q[$];
  int           pulse_log[$];

  // Reference model state
  int         cyc = 0;
  logic [3:0] m_cmd;
  logic       m_en;
  logic [7:0] m_period;
  logic [7:0] m_count;
  logic       m_pending;
  int         m_last_pulse;
  int         m_start;
  logic [3:0] m_command_out;

  ir_command_controller #(
    .BASE_ADDR      (BASE),
    .TICK_CYCLES    (TICK),
    .HOLDOFF_CYCLES (HOLD),
    .PERIOD_RESET   (8'd99)
  ) dut (
    .CLK         (clk),
    .RESETN      (resetn),
    .BUS_ADDR    (bus_addr),
    .BUS_WDATA   (bus_wdata),
    .BUS_WE      (bus_we),
    .BUS_RE      (bus_re),
    .BUS_RDATA   (bus_rdata),
    .COMMAND     (command),
    .SEND_PACKET (send_packet)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queues exp=%0d pulse=%0d", exp_q.size(), pulse_q.size());
    failed++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $fatal(1, "watchdog");
  end

  // Reference model: pulses occur when a request exists and hold-off since the
  // last pulse has elapsed; periodic requests fall every (N+1)*TICK cycles
  // after the timer was started.
  task automatic model_step();
    logic [7:0] off;
    logic       hit;
    logic [7:0] rv;
    logic       wr_period;
    logic       periodic;
    logic       req;
    int         per_len;
    cyc++;
    if (!resetn) begin
      m_cmd         = 4'h0;
      m_en          = 1'b0;
      m_period      = 8'd99;
      m_count       = 8'd0;
      m_pending     = 1'b0;
      m_last_pulse  = -100000;
      m_start       = 0;
      m_command_out = 4'h0;
    end else begin
      off = bus_addr - BASE;
      hit = (off < 8'd4);
      if (bus_re) begin
        rv = 8'h00;
        if (hit) begin
          case (off[1:0])
            2'd0:    rv = {4'h0, m_cmd};
            2'd1:    rv = {7'h00, m_en};
            2'd2:    rv = m_count;
            default: rv = m_period;
          endcase
        end
        exp_q.push_back({32'(cyc), rv});
      end
      wr_period = bus_we && hit && (off == 8'd3);
      per_len   = (int'(m_period) + 1) * TICK;
      periodic  = m_en && !wr_period && (cyc > m_start) && (((cyc - m_start) % per_len) == 0);
      req       = (bus_we && hit && (off == 8'd1) && bus_wdata[1]) || periodic;
      if ((m_pending || req) && (cyc >= m_last_pulse + HOLD + 1)) begin
        pulse_q.push_back({32'(cyc), 4'h0, m_cmd});
        m_command_out = m_cmd;
        m_count       = m_count + 8'd1;
        m_pending     = 1'b0;
        m_last_pulse  = cyc;
      end else if (req) begin
        m_pending = 1'b1;
      end
      if (bus_we && hit) begin
        case (off[1:0])
          2'd0: m_cmd = bus_wdata[3:0];
          2'd1: begin
            if (!m_en && bus_wdata[0]) m_start = cyc;
            m_en = bus_wdata[0];
          end
          2'd3: begin
            m_period = bus_wdata;
            m_start  = cyc;
          end
          default: ;
        endcase
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Monitor: compares read data, pulses and the COMMAND output each cycle
  task automatic monitor_step();
    logic [W-1:0] e;
    if (exp_q.size() > 0 && int'(exp_q[0][39:8]) == cyc) begin
      e = exp_q.pop_front();
      compared++;
      if (bus_rdata !== e[7:0]) begin
        failed++;
        $display("FAIL rdata @%0d: got %02h expected %02h", cyc, bus_rdata, e[7:0]);
      end
    end else if (bus_rdata !== 8'h00) begin
      compared++;
      failed++;
      $display("FAIL rdata_idle @%0d: got %02h expected 00", cyc, bus_rdata);
    end
    if (send_packet === 1'b1) begin
      pulse_log.push_back(cyc);
      compared++;
      if (pulse_q.size() == 0) begin
        failed++;
        $display("FAIL pulse_unexpected @%0d: got pulse expected none", cyc);
      end else begin
        e = pulse_q.pop_front();
        if (int'(e[39:8]) != cyc || command !== e[3:0]) begin
          failed++;
          $display("FAIL pulse @%0d: got cycle %0d cmd %h expected cycle %0d cmd %h", cyc, cyc, command, e[39:8], e[3:0]);
        end
      end
    end else begin
      if (send_packet !== 1'b0) begin
        compared++;
        failed++;
        $display("FAIL send_packet_x @%0d: got %b expected 0", cyc, send_packet);
      end
      if (pulse_q.size() > 0 && int'(pulse_q[0][39:8]) <= cyc) begin
        e = pulse_q.pop_front();
        compared++;
        failed++;
        $display("FAIL pulse_missing @%0d: got none expected pulse at %0d cmd %h", cyc, e[39:8], e[3:0]);
      end
    end
    compared++;
    if (command !== m_command_out) begin
      failed++;
      $display("FAIL command @%0d: got %h expected %h", cyc, command, m_command_out);
    end
  endtask

  always @(negedge clk) monitor_step();

  // Driver tasks: called and return on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    bus_addr = a;
    bus_re   = 1'b1;
    @(negedge clk);
    bus_re   = 1'b0;
  endtask

  task automatic apply_reset();
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus
  initial begin
    int n0;
    int p0;
    int wait_cnt;
    logic [7:0] a;
    logic [7:0] d;
    resetn    = 1'b0;
    bus_addr  = 8'h00;
    bus_wdata = 8'h00;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    repeat (5) @(negedge clk);
    resetn = 1'b1;

    // Reset values and quiet period
    for (int i = 0; i < 4; i++) bus_read(BASE + 8'(i));
    n0 = pulse_log.size();
    idle(1000);
    @(posedge clk);
    check("no_pulse_after_reset", pulse_log.size() - n0, 0);
    @(negedge clk);

    // Software send
    n0 = pulse_log.size();
    bus_write(BASE + 8'd0, 8'h05);
    bus_write(BASE + 8'd1, 8'h02);
    idle(3);
    bus_read(BASE + 8'd2);
    bus_read(BASE + 8'd1);
    @(posedge clk);
    check("single_send_pulses", pulse_log.size() - n0, 1);
    @(negedge clk);

    // Periodic every 40 cycles, then disabled
    idle(30);
    n0 = pulse_log.size();
    bus_write(BASE + 8'd3, 8'h03);
    bus_write(BASE + 8'd1, 8'h01);
    idle(170);
    bus_write(BASE + 8'd1, 8'h00);
    idle(100);
    @(posedge clk);
    check("periodic_count", pulse_log.size() - n0, 4);
    for (int i = n0 + 1; i < pulse_log.size(); i++)
      check("periodic_spacing", pulse_log[i] - pulse_log[i-1], 40);
    @(negedge clk);

    // Requests during hold-off collapse into one pulse
    n0 = pulse_log.size();
    bus_write(BASE + 8'd1, 8'h02);
    for (int i = 0; i < 3; i++) begin
      bus_write(BASE + 8'd0, 8'h0A);
      bus_write(BASE + 8'd1, 8'h02);
    end
    idle(40);
    @(posedge clk);
    check("holdoff_pulses", pulse_log.size() - n0, 2);
    if (pulse_log.size() - n0 == 2)
      check("holdoff_spacing", pulse_log[n0+1] - pulse_log[n0], 21);
    check("command_after_holdoff", int'(command), 10);
    @(negedge clk);

    // 256 sends wrap STATUS; unmapped accesses
    apply_reset();
    n0 = pulse_log.size();
    for (int i = 0; i < 256; i++) begin
      bus_write(BASE + 8'd1, 8'h02);
      idle(21);
    end
    bus_read(BASE + 8'd2);
    bus_write(BASE + 8'd4, 8'hFF);
    bus_write(BASE - 8'd1, 8'hFF);
    bus_write(8'h00, 8'hFF);
    for (int i = -1; i < 5; i++) bus_read(BASE + 8'(i));
    idle(2);
    @(posedge clk);
    check("wrap_send_count", pulse_log.size() - n0, 256);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          a = BASE - 8'd2 + 8'($urandom_range(0, 7));
          d = 8'($urandom_range(0, 255));
          if (a == BASE + 8'd3) d = 8'($urandom_range(0, 7));
          if (a == BASE + 8'd1) d = 8'($urandom_range(0, 3));
          bus_write(a, d);
        end
        4, 5, 6: bus_read(BASE - 8'd2 + 8'($urandom_range(0, 7)));
        default: idle($urandom_range(1, 15));
      endcase
    end

    // Reset mid-holdoff with a request pending
    bus_write(BASE + 8'd1, 8'h00);
    idle(30);
    bus_write(BASE + 8'd0, 8'h07);
    bus_write(BASE + 8'd1, 8'h02);
    idle(5);
    bus_write(BASE + 8'd1, 8'h02);
    idle(2);
    apply_reset();
    p0 = pulse_log.size();
    idle(100);
    @(posedge clk);
    check("no_pulse_after_mid_reset", pulse_log.size() - p0, 0);
    check("command_after_mid_reset", int'(command), 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) bus_read(BASE + 8'(i));

    // Drain
    wait_cnt = 0;
    while ((exp_q.size() > 0 || pulse_q.size() > 0) && wait_cnt < 200) begin
      @(negedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d reads %0d pulses outstanding expected 0", exp_q.size(), pulse_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
